mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares Memory's single data port (address/data/writeMode/readMode/unsignedLoad -> dataOutput) between the CPU load/store unit and the program loader.
//  CPU accesses are single-beat; loader accesses are WORD bursts at word-aligned, auto-incrementing addresses. Sits between the core/loader and Memory; pcAddress path untouched.
// PARAMETERS
//  MAX_BURST     16  max loader burst length in words; LW = $clog2(MAX_BURST+1)
//  STARVE_LIMIT  8   consecutive CPU-granted cycles with ld_req high before loader is forced in
// PORTS
//  clk               in   1   clock, all state on rising edge
//  rst               in   1   reset, asynchronous, active-low
//  cpu_req           in   1   CPU access request (level)
//  cpu_addr          in   32  CPU byte address
//  cpu_wdata         in   32  CPU store data
//  cpu_writeMode     in   3   MemoryModes store mode (NONE/BYTE/HALFWORD/WORD/WORDLEFT)
//  cpu_readMode      in   3   MemoryModes load mode
//  cpu_unsignedLoad  in   1   zero-extend CPU load
//  cpu_gnt           out  1   CPU access performed this cycle (comb.)
//  ld_req            in   1   loader burst request (level)
//  ld_we             in   1   1 = burst write, 0 = burst read; sampled at burst accept
//  ld_addr           in   32  burst start address; bits[1:0] forced 0
//  ld_len            in   LW  burst length in words, 1..MAX_BURST
//  ld_wdata          in   32  write data for current beat
//  ld_gnt            out  1   1-cycle pulse: burst accepted
//  ld_beat           out  1   loader beat performed this cycle (write consumed / rdata valid)
//  ld_done           out  1   1-cycle registered pulse after last beat
//  rdata             out  32  = dataOutput (comb.), valid when cpu_gnt, or ld_beat & !ld_we
//  address           out  32  to Memory
//  data              out  32  to Memory
//  writeMode         out  3   to Memory
//  readMode          out  3   to Memory
//  unsignedLoad      out  1   to Memory
//  dataOutput        in   32  from Memory
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, counters 0, ld_gnt/ld_beat/ld_done=0, writeMode=readMode=NONE, address=data=0, unsignedLoad=0.
//  - FSM IDLE <-> BURST. IDLE: CPU has priority. cpu_gnt = cpu_req & !(ld_req & starve==STARVE_LIMIT). When cpu_gnt, CPU fields pass to Memory the same cycle.
//  - Latency: stores commit at the edge ending the grant cycle; load data are on rdata in the grant cycle (0 cycles).
//  - IDLE & ld_req & !cpu_gnt: ld_gnt=1 (comb.). Latch base={ld_addr[31:2],2'b00}, ld_we, beats=ld_len. Go to BURST next edge. ld_len==0: ld_gnt pulses, no beats, ld_done next cycle, stay IDLE.
//  - BURST: every cycle is one beat, no stalls. address=base+4*k, WORD mode in the direction set by ld_we, unsignedLoad=0, ld_beat=1, cpu_gnt=0.
//  - The loader presents the next ld_wdata each beat. The address wraps mod 2^32.
//  - After beat len-1: go to IDLE; ld_done=1 for the following cycle. ld_req still high then = new request.
//  - starve: +1 per cycle with cpu_gnt & ld_req, saturating at STARVE_LIMIT. Cleared on ld_gnt or when ld_req=0.
//  - Idle cycles and denied requests: writeMode=readMode=NONE; address/data hold the last value.
//  - Reset mid-burst abandons the burst: beats already written stay; no ld_done.
// TESTING
//  - CPU WORD store 0x22345678 @65532, then WORD load: cpu_gnt both cycles, rdata=0x22345678 in the load cycle.
//  - Loader write burst ld_addr=65530 (aligned to 65528), len=3, data 0x11,0x22,0x33:
//    ld_gnt 1 cycle, then ld_beat 3 cycles, ld_done next cycle.
//    CPU reads 65528/65532/65536 = 0x11/0x22/0x33.
//  - cpu_req high throughout a burst: cpu_gnt=0 for all beats, then 1 on the first IDLE cycle after the last beat.
//  - cpu_req and ld_req both held high: CPU granted exactly 8 cycles, then ld_gnt; starve returns to 0.
//  - Loader read burst @0xFFFFFFFC, len=2: addresses 0xFFFFFFFC then 0x00000000 (wrap); rdata matches preloaded words.
//  - rst=0 during beat 2 of a len=4 write: outputs reset immediately, no ld_done.
//    Beats 0-1 stored, beats 2-3 unchanged; a CPU access succeeds after release.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares Memory's single data port between single-beat CPU accesses and word-aligned
// loader bursts. The CPU has priority, and a starvation counter forces the loader in.
module mem_port_arbiter #(
   parameter int MAX_BURST    = 16,
   parameter int STARVE_LIMIT = 8,
   parameter int LW           = $clog2(MAX_BURST + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic [31:0]   cpu_addr,
   input  logic [31:0]   cpu_wdata,
   input  logic [2:0]    cpu_writeMode,
   input  logic [2:0]    cpu_readMode,
   input  logic          cpu_unsignedLoad,
   output logic          cpu_gnt,
   input  logic          ld_req,
   input  logic          ld_we,
   input  logic [31:0]   ld_addr,
   input  logic [LW-1:0] ld_len,
   input  logic [31:0]   ld_wdata,
   output logic          ld_gnt,
   output logic          ld_beat,
   output logic          ld_done,
   output logic [31:0]   rdata,
   output logic [31:0]   address,
   output logic [31:0]   data,
   output logic [2:0]    writeMode,
   output logic [2:0]    readMode,
   output logic          unsignedLoad,
   input  logic [31:0]   dataOutput
);

   localparam int         SW        = $clog2(STARVE_LIMIT + 1);
   localparam logic [2:0] MODE_NONE = 3'd0;
   localparam logic [2:0] MODE_WORD = 3'd3;

   typedef enum logic {IDLE, BURST} state_t;

   state_t        state, state_next;
   logic [31:0]   base, addr_q, data_q, beat_addr;
   logic          burst_we, done_q, last_beat, starve_hit;
   logic [LW-1:0] beats, beat_idx;
   logic [SW-1:0] starve;

   assign beat_addr  = base + (32'(beat_idx) << 2);
   assign last_beat  = (beat_idx == beats - LW'(1));
   assign starve_hit = ld_req && (starve == SW'(STARVE_LIMIT));
   assign rdata      = dataOutput;
   assign ld_done    = done_q;

   // Grants are gated by rst so the Memory port goes quiet the moment reset asserts.
   // NOTE: combinational logic uses blocking assignments, and every output gets a
   // default first so no latch is inferred on paths that do not assign it.
   always_comb begin
      state_next   = state;
      cpu_gnt      = 1'b0;
      ld_gnt       = 1'b0;
      ld_beat      = 1'b0;
      address      = addr_q;
      data         = data_q;
      writeMode    = MODE_NONE;
      readMode     = MODE_NONE;
      unsignedLoad = 1'b0;
      if (rst) begin
         case (state)
            IDLE: begin
               cpu_gnt = cpu_req && !starve_hit;
               if (cpu_gnt) begin
                  address      = cpu_addr;
                  data         = cpu_wdata;
                  writeMode    = cpu_writeMode;
                  readMode     = cpu_readMode;
                  unsignedLoad = cpu_unsignedLoad;
               end else if (ld_req) begin
                  ld_gnt = 1'b1;
                  if (ld_len != '0) state_next = BURST;
               end
            end
            BURST: begin
               ld_beat = 1'b1;
               address = beat_addr;
               if (burst_we) begin
                  data      = ld_wdata;
                  writeMode = MODE_WORD;
               end else begin
                  readMode = MODE_WORD;
               end
               if (last_beat) state_next = IDLE;
            end
         endcase
      end
   end

   // NOTE: clocked state uses non-blocking assignments only, so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         base     <= '0;
         burst_we <= 1'b0;
         beats    <= '0;
         beat_idx <= '0;
         starve   <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         state  <= state_next;
         addr_q <= address;
         data_q <= data;
         done_q <= (state == BURST && last_beat) || (ld_gnt && ld_len == '0);
         if (ld_gnt) begin
            base     <= ld_addr & 32'hFFFF_FFFC;
            burst_we <= ld_we;
            beats    <= ld_len;
            beat_idx <= '0;
         end else if (state == BURST) begin
            beat_idx <= beat_idx + LW'(1);
         end
         if (ld_gnt || !ld_req)
            starve <= '0;
         else if (cpu_gnt && starve != SW'(STARVE_LIMIT))
            starve <= starve + SW'(1);
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural word memory; read results are
// checked through a scoreboard filled when reads are issued and drained as they occur.
module tb_mem_port_arbiter;

   localparam int         LW     = $clog2(17);
   localparam logic [2:0] M_NONE = 3'd0;
   localparam logic [2:0] M_WORD = 3'd3;

   logic          clk = 1'b0;
   logic          rst;
   logic          cpu_req, cpu_unsignedLoad, cpu_gnt;
   logic [31:0]   cpu_addr, cpu_wdata;
   logic [2:0]    cpu_writeMode, cpu_readMode;
   logic          ld_req, ld_we, ld_gnt, ld_beat, ld_done;
   logic [31:0]   ld_addr, ld_wdata;
   logic [LW-1:0] ld_len;
   logic [31:0]   rdata, address, data, dataOutput;
   logic [2:0]    writeMode, readMode;
   logic          unsignedLoad;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] value;
      string       tag;
   } exp_t;

   exp_t        sb[$];
   int          compared   = 0;
   int          mismatched = 0;
   logic [31:0] mem [256];

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_writeMode(cpu_writeMode), .cpu_readMode(cpu_readMode),
      .cpu_unsignedLoad(cpu_unsignedLoad), .cpu_gnt(cpu_gnt),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_len(ld_len),
      .ld_wdata(ld_wdata), .ld_gnt(ld_gnt), .ld_beat(ld_beat), .ld_done(ld_done),
      .rdata(rdata), .address(address), .data(data), .writeMode(writeMode),
      .readMode(readMode), .unsignedLoad(unsignedLoad), .dataOutput(dataOutput)
   );

   // Word memory: combinational read, WORD store committed at the clock edge.
   always_comb dataOutput = mem[address[9:2]];
   always @(posedge clk) if (writeMode == M_WORD) mem[address[9:2]] <= data;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst === 1'b1 && readMode != M_NONE) begin
         if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL unexpected_read: observed address=0x%08h expected no read", address);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, " addr"}, address, e.addr);
            check({e.tag, " rdata"}, rdata, e.value);
         end
      end
   end

   task automatic cpu_op(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input string tag);
      cpu_req          = 1'b1;
      cpu_addr         = a;
      cpu_wdata        = d;
      cpu_writeMode    = we ? M_WORD : M_NONE;
      cpu_readMode     = we ? M_NONE : M_WORD;
      cpu_unsignedLoad = !we;
      if (!we) sb.push_back('{a, exp_rd, tag});
      @(negedge clk);
      check({tag, " cpu_gnt"}, cpu_gnt, 1);
      check({tag, " address"}, address, a);
      check({tag, " unsignedLoad"}, unsignedLoad, !we);
      @(posedge clk); #1;
      cpu_req       = 1'b0;
      cpu_writeMode = M_NONE;
      cpu_readMode  = M_NONE;
   endtask

   task automatic ld_burst(input logic we, input logic [31:0] a, input int len,
                           input logic [31:0] d0, input logic [31:0] step, input string tag);
      logic [31:0] base;
      base    = a & 32'hFFFF_FFFC;
      ld_req  = 1'b1;
      ld_we   = we;
      ld_addr = a;
      ld_len  = LW'(len);
      @(negedge clk);
      check({tag, " ld_gnt"}, ld_gnt, 1);
      check({tag, " no beat in gnt cycle"}, ld_beat, 0);
      @(posedge clk); #1;
      ld_req  = 1'b0;
      ld_we   = !we;
      ld_addr = 32'hDEAD_BEEF;
      for (int i = 0; i < len; i++) begin
         ld_wdata = d0 + step * i;
         if (!we) sb.push_back('{base + 4 * i, d0 + step * i, $sformatf("%s beat%0d", tag, i)});
         @(negedge clk);
         check($sformatf("%s beat%0d ld_beat", tag, i), ld_beat, 1);
         check($sformatf("%s beat%0d address", tag, i), address, base + 4 * i);
         check($sformatf("%s beat%0d writeMode", tag, i), writeMode, we ? M_WORD : M_NONE);
         check($sformatf("%s beat%0d cpu_gnt", tag, i), cpu_gnt, 0);
         check($sformatf("%s beat%0d ld_done", tag, i), ld_done, 0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      check({tag, " ld_done"}, ld_done, 1);
      check({tag, " beat after last"}, ld_beat, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b0;
      cpu_req = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_unsignedLoad = 1'b0;
      cpu_writeMode = M_NONE; cpu_readMode = M_NONE;
      ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_len = '0; ld_wdata = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset address", address, 0);
      check("reset data", data, 0);
      check("reset writeMode", writeMode, M_NONE);
      check("reset readMode", readMode, M_NONE);
      check("reset unsignedLoad", unsignedLoad, 0);
      check("reset ld_gnt/beat/done", {ld_gnt, ld_beat, ld_done}, 0);
      @(posedge clk); #1;
      rst = 1'b1;

      cpu_op(1'b1, 32'd65532, 32'h2234_5678, 32'h0, "cpu store");
      cpu_op(1'b0, 32'd65532, 32'h0, 32'h2234_5678, "cpu load");
      @(negedge clk);
      check("idle writeMode", writeMode, M_NONE);
      check("idle readMode", readMode, M_NONE);
      check("idle address hold", address, 32'd65532);
      @(posedge clk); #1;

      ld_burst(1'b1, 32'd65530, 3, 32'h11, 32'h11, "wburst");
      cpu_op(1'b0, 32'd65528, 32'h0, 32'h11, "rd 65528");
      cpu_op(1'b0, 32'd65532, 32'h0, 32'h22, "rd 65532");
      cpu_op(1'b0, 32'd65536, 32'h0, 32'h33, "rd 65536");

      // Both requesters held high: 8 CPU grants, then the loader; starve restarts at 0.
      cpu_req = 1'b1; cpu_addr = 32'h300;
      ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h200; ld_len = LW'(2);
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("starve r%0d c%0d cpu_gnt", r, i), cpu_gnt, 1);
            check($sformatf("starve r%0d c%0d ld_gnt", r, i), ld_gnt, 0);
            if (i == 0) check($sformatf("starve r%0d ld_done", r), ld_done, (r == 1));
            @(posedge clk); #1;
         end
         @(negedge clk);
         check($sformatf("starve r%0d forced cpu_gnt", r), cpu_gnt, 0);
         check($sformatf("starve r%0d forced ld_gnt", r), ld_gnt, 1);
         @(posedge clk); #1;
         if (r == 1) ld_req = 1'b0;
         for (int b = 0; b < 2; b++) begin
            ld_wdata = 32'h5000 + b;
            @(negedge clk);
            check($sformatf("starve r%0d beat%0d cpu_gnt", r, b), cpu_gnt, 0);
            check($sformatf("starve r%0d beat%0d ld_beat", r, b), ld_beat, 1);
            @(posedge clk); #1;
         end
      end
      @(negedge clk);
      check("post-burst cpu_gnt", cpu_gnt, 1);
      check("post-burst ld_done", ld_done, 1);
      @(posedge clk); #1;
      cpu_req = 1'b0;

      cpu_op(1'b1, 32'hFFFF_FFFC, 32'hCAFE_0001, 32'h0, "preload top");
      cpu_op(1'b1, 32'h0000_0000, 32'hCAFE_0002, 32'h0, "preload zero");
      ld_burst(1'b0, 32'hFFFF_FFFC, 2, 32'hCAFE_0001, 32'h1, "rburst wrap");

      ld_burst(1'b1, 32'h0000_0040, 0, 32'h0, 32'h0, "len0");

      for (int i = 0; i < 4; i++)
         cpu_op(1'b1, 32'h100 + 4 * i, 32'hA0 + i, 32'h0, $sformatf("preload rst%0d", i));
      ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h100; ld_len = LW'(4);
      @(negedge clk);
      check("rstburst ld_gnt", ld_gnt, 1);
      @(posedge clk); #1;
      ld_req = 1'b0;
      for (int i = 0; i < 2; i++) begin
         ld_wdata = 32'hB0 + i;
         @(negedge clk);
         check($sformatf("rstburst beat%0d", i), ld_beat, 1);
         @(posedge clk); #1;
      end
      ld_wdata = 32'hB2;
      #2;
      check("rstburst beat2 address", address, 32'h108);
      rst = 1'b0;
      #1;
      check("rstburst async ld_beat", ld_beat, 0);
      check("rstburst async writeMode", writeMode, M_NONE);
      check("rstburst async address", address, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("rstburst no ld_done c%0d", i), ld_done, 0);
         check($sformatf("rstburst no beat c%0d", i), ld_beat, 0);
         @(posedge clk); #1;
      end
      cpu_op(1'b0, 32'h100, 32'h0, 32'hB0, "rst rd0");
      cpu_op(1'b0, 32'h104, 32'h0, 32'hB1, "rst rd1");
      cpu_op(1'b0, 32'h108, 32'h0, 32'hA2, "rst rd2");
      cpu_op(1'b0, 32'h10C, 32'h0, 32'hA3, "rst rd3");

      @(negedge clk);
      check("scoreboard drained", 32'(sb.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
